cfu_l1_arbiter: RTL and testbench

//  Shares one fixed-latency CFU-L1 unit (e.g. mulacc_cfu) among N_REQ requesters.
//  - Each requester has a valid/ready request port and a valid/ready response port.
//  - Requests are arbitrated round-robin; a tag pipeline of depth CFU_LATENCY tracks who issued each in-flight request.
//  - Each response is steered into its requester's response FIFO. Credits keep the CFU response from ever being dropped.

---
 rtl/cfu_l1_arbiter_if.sv | 27 ++
 rtl/cfu_l1_arbiter.sv | 117 +++++++++++
 tb/tb_cfu_l1_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfu_l1_arbiter_if.sv
// cfu_l1_arbiter_if: per-requester request/response bundle between requesters and the CFU-L1 arbiter
interface cfu_l1_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int CFU_STATE_ID_W = 1,
  parameter int CFU_FUNC_ID_W = 10,
  parameter int CFU_DATA_W = 32,
  parameter int CFU_STATUS_W = 3
) ();
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ-1:0][CFU_STATE_ID_W-1:0] req_state;
  logic [N_REQ-1:0][CFU_FUNC_ID_W-1:0] req_func;
  logic [N_REQ-1:0][CFU_DATA_W-1:0] req_data0;
  logic [N_REQ-1:0][CFU_DATA_W-1:0] req_data1;
  logic [N_REQ-1:0] resp_valid;
  logic [N_REQ-1:0] resp_ready;
  logic [N_REQ-1:0][CFU_STATUS_W-1:0] resp_status;
  logic [N_REQ-1:0][CFU_DATA_W-1:0] resp_data;
  modport master (
    output req_valid, req_state, req_func, req_data0, req_data1, resp_ready,
    input  req_ready, resp_valid, resp_status, resp_data
  );
  modport slave (
    input  req_valid, req_state, req_func, req_data0, req_data1, resp_ready,
    output req_ready, resp_valid, resp_status, resp_data
  );
endinterface

// File: rtl/cfu_l1_arbiter.sv
// cfu_l1_arbiter: round-robin sharing of one fixed-latency CFU-L1 among N_REQ requesters with credit-protected response FIFOs
module cfu_l1_arbiter #(
  parameter int N_REQ = 2,
  parameter int CFU_LATENCY = 0,
  parameter int RESP_DEPTH = 2,
  parameter int CFU_STATE_ID_W = 1,
  parameter int CFU_FUNC_ID_W = 10,
  parameter int CFU_DATA_W = 32,
  parameter int CFU_STATUS_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  cfu_l1_arbiter_if.slave bus,
  output logic cfu_clk_en,
  output logic cfu_req_valid,
  output logic [CFU_STATE_ID_W-1:0] cfu_req_state,
  output logic [CFU_FUNC_ID_W-1:0] cfu_req_func,
  output logic [CFU_DATA_W-1:0] cfu_req_data0,
  output logic [CFU_DATA_W-1:0] cfu_req_data1,
  input  logic cfu_resp_valid,
  input  logic [CFU_STATUS_W-1:0] cfu_resp_status,
  input  logic [CFU_DATA_W-1:0] cfu_resp_data
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = RESP_DEPTH > 1 ? $clog2(RESP_DEPTH) : 1;
  localparam int EW = CFU_STATUS_W + CFU_DATA_W;

  logic [IW-1:0] ptr, gnt, idx, tag_i;
  logic found, tag_v;
  logic [N_REQ-1:0][CW-1:0] cred, cnt;
  logic [N_REQ-1:0][PW-1:0] rd, wr;
  logic [N_REQ-1:0] push, pop;
  logic [EW-1:0] mem [N_REQ][RESP_DEPTH];

  // first requester with a pending request and a free credit, scanning upward from ptr
  always_comb begin
    found = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % N_REQ);
      if (!found && clk_en && bus.req_valid[idx] && cred[idx] != '0) begin
        found = 1'b1;
        gnt = idx;
      end
    end
  end

  assign cfu_clk_en = clk_en;
  assign cfu_req_valid = found;
  assign cfu_req_state = bus.req_state[gnt];
  assign cfu_req_func = bus.req_func[gnt];
  assign cfu_req_data0 = bus.req_data0[gnt];
  assign cfu_req_data1 = bus.req_data1[gnt];

  if (CFU_LATENCY == 0) begin : g_wire
    assign tag_v = found;
    assign tag_i = gnt;
  end else begin : g_pipe
    logic [CFU_LATENCY-1:0] tv;
    logic [IW-1:0] ti [CFU_LATENCY];
    // issuer tags travel alongside the CFU pipeline and freeze with it
    always_ff @(posedge clk) begin
      if (rst) tv <= '0;
      else if (clk_en) begin
        tv[0] <= found;
        ti[0] <= gnt;
        for (int k = 1; k < CFU_LATENCY; k++) begin
          tv[k] <= tv[k-1];
          ti[k] <= ti[k-1];
        end
      end
    end
    assign tag_v = tv[CFU_LATENCY-1];
    assign tag_i = ti[CFU_LATENCY-1];
  end

  // per-requester handshakes and FIFO heads
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      push[i] = cfu_resp_valid && clk_en && tag_v && tag_i == IW'(i);
      pop[i] = cnt[i] != '0 && bus.resp_ready[i];
      bus.req_ready[i] = found && gnt == IW'(i);
      bus.resp_valid[i] = cnt[i] != '0;
      {bus.resp_status[i], bus.resp_data[i]} = mem[i][rd[i]];
    end
  end

  // rr pointer, credits (returned on pop) and response FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
      rd <= '0;
      wr <= '0;
      for (int i = 0; i < N_REQ; i++) cred[i] <= CW'(RESP_DEPTH);
    end else begin
      if (found) ptr <= gnt == IW'(N_REQ - 1) ? '0 : gnt + 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        cred[i] <= cred[i] - CW'(bus.req_ready[i]) + CW'(pop[i]);
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
        if (push[i]) begin
          mem[i][wr[i]] <= {cfu_resp_status, cfu_resp_data};
          wr[i] <= wr[i] == PW'(RESP_DEPTH - 1) ? '0 : wr[i] + 1'b1;
        end
        if (pop[i]) rd[i] <= rd[i] == PW'(RESP_DEPTH - 1) ? '0 : rd[i] + 1'b1;
      end
    end
  end

  a_tagged: assert property (@(posedge clk) disable iff (rst) cfu_resp_valid && clk_en |-> tag_v);
  for (genvar i = 0; i < N_REQ; i++) begin : g_ovf
    a_room: assert property (@(posedge clk) disable iff (rst) push[i] |-> cnt[i] != CW'(RESP_DEPTH) || pop[i]);
  end
endmodule

// File: tb/tb_cfu_l1_arbiter.sv
// tb_cfu_l1_arbiter: randomized and directed check of the CFU-L1 arbiter against a queue-based reference model
module tb_cfu_l1_arbiter;
  localparam int N = 2;
  localparam int LAT = 2;
  localparam int DEPTH = 2;
  localparam logic [2:0] CFU_OK = 3'd0;
  localparam logic [2:0] CFU_ERROR_FUNC = 3'd2;

  typedef struct {
    int who;
    int rem;
    logic [34:0] val;
  } fl_t;

  logic clk = 1'b0;
  logic rst, clk_en;
  logic cfu_clk_en, cfu_req_valid, cfu_resp_valid;
  logic [0:0] cfu_req_state;
  logic [9:0] cfu_req_func;
  logic [31:0] cfu_req_data0, cfu_req_data1, cfu_resp_data;
  logic [2:0] cfu_resp_status;

  cfu_l1_arbiter_if #(.N_REQ(N), .CFU_STATE_ID_W(1), .CFU_FUNC_ID_W(10), .CFU_DATA_W(32), .CFU_STATUS_W(3)) bus ();

  cfu_l1_arbiter #(
    .N_REQ(N), .CFU_LATENCY(LAT), .RESP_DEPTH(DEPTH),
    .CFU_STATE_ID_W(1), .CFU_FUNC_ID_W(10), .CFU_DATA_W(32), .CFU_STATUS_W(3)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus),
    .cfu_clk_en(cfu_clk_en), .cfu_req_valid(cfu_req_valid),
    .cfu_req_state(cfu_req_state), .cfu_req_func(cfu_req_func),
    .cfu_req_data0(cfu_req_data0), .cfu_req_data1(cfu_req_data1),
    .cfu_resp_valid(cfu_resp_valid), .cfu_resp_status(cfu_resp_status), .cfu_resp_data(cfu_resp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] cfu_fn(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p, s;
    p = a * b;
    s = a + b;
    return f == 10'd0 ? {CFU_OK, p} : f == 10'd1 ? {CFU_OK, s} : {CFU_ERROR_FUNC, 32'h0};
  endfunction

  // stand-in shared CFU: fixed two-stage pipeline, frozen by cfu_clk_en, cleared by reset
  logic [1:0] cv;
  logic [34:0] cr [2];
  always @(posedge clk) begin
    if (rst) cv <= 2'b00;
    else if (cfu_clk_en) begin
      cv <= {cv[0], cfu_req_valid};
      cr[0] <= cfu_fn(cfu_req_func, cfu_req_data0, cfu_req_data1);
      cr[1] <= cr[0];
    end
  end
  assign cfu_resp_valid = cv[1];
  assign {cfu_resp_status, cfu_resp_data} = cr[1];

  logic s_rst, s_en;
  logic [1:0] s_valid, s_rr;
  logic [1:0][0:0] s_state;
  logic [1:0][9:0] s_func;
  logic [1:0][31:0] s_d0, s_d1;

  int errors = 0;
  int checks = 0;
  int mptr;
  int mg;
  logic [1:0] mpop;
  fl_t fl[$];
  logic [34:0] expq [2][$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // drive this cycle's inputs, then compare every DUT output with the model
  task automatic pre();
    int outst;
    logic [1:0] exp_ready;
    @(negedge clk);
    rst = s_rst;
    clk_en = s_en;
    bus.req_valid = s_valid;
    bus.resp_ready = s_rr;
    bus.req_state = s_state;
    bus.req_func = s_func;
    bus.req_data0 = s_d0;
    bus.req_data1 = s_d1;
    #1;
    mg = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (mptr + k) % N;
      outst = expq[j].size();
      foreach (fl[e]) if (fl[e].who == j) outst++;
      if (mg < 0 && s_en && s_valid[j] && outst < DEPTH) mg = j;
    end
    exp_ready = mg >= 0 ? 2'(1 << mg) : 2'b00;
    for (int i = 0; i < N; i++) mpop[i] = expq[i].size() > 0 && s_rr[i];
    if (!s_rst) begin
      chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      chk("cfu_req_valid", 64'(cfu_req_valid), 64'(mg >= 0));
      chk("cfu_clk_en", 64'(cfu_clk_en), 64'(s_en));
      if (mg >= 0) begin
        chk("cfu_req_func", 64'(cfu_req_func), 64'(s_func[mg]));
        chk("cfu_req_state", 64'(cfu_req_state), 64'(s_state[mg]));
        chk("cfu_req_data0", 64'(cfu_req_data0), 64'(s_d0[mg]));
        chk("cfu_req_data1", 64'(cfu_req_data1), 64'(s_d1[mg]));
      end
      for (int i = 0; i < N; i++) begin
        chk($sformatf("resp_valid[%0d]", i), 64'(bus.resp_valid[i]), 64'(expq[i].size() > 0));
        if (expq[i].size() > 0)
          chk($sformatf("resp_head[%0d]", i), 64'({bus.resp_status[i], bus.resp_data[i]}), 64'(expq[i][0]));
      end
    end
  endtask

  // advance the model across the clock edge
  task automatic post();
    fl_t e;
    @(posedge clk);
    if (s_rst) begin
      fl = {};
      expq[0] = {};
      expq[1] = {};
      mptr = 0;
    end else begin
      for (int i = 0; i < N; i++) if (mpop[i]) void'(expq[i].pop_front());
      if (s_en) begin
        while (fl.size() > 0 && fl[0].rem == 0) begin
          e = fl.pop_front();
          expq[e.who].push_back(e.val);
        end
        foreach (fl[k]) fl[k].rem--;
      end
      if (mg >= 0) begin
        e.who = mg;
        e.rem = LAT - 1;
        e.val = cfu_fn(s_func[mg], s_d0[mg], s_d1[mg]);
        if (LAT == 0) expq[mg].push_back(e.val);
        else fl.push_back(e);
        mptr = (mg + 1) % N;
      end
    end
  endtask

  task automatic idle(input int n);
    s_valid = 2'b00;
    repeat (n) begin
      pre();
      post();
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      int r;
      r = $urandom_range(0, 5);
      s_func[i] = r < 3 ? 10'd0 : r < 5 ? 10'd1 : 10'd5;
      s_d0[i] = $urandom;
      s_d1[i] = $urandom;
      s_state[i] = 1'($urandom);
    end
  endtask

  initial begin
    int mode;
    logic [1:0] rr_fix;
    rst = 1'b1;
    clk_en = 1'b0;
    bus.req_valid = '0;
    bus.resp_ready = '0;
    bus.req_state = '0;
    bus.req_func = '0;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
    mptr = 0;
    s_rst = 1'b1;
    s_en = 1'b0;
    s_valid = 2'b00;
    s_rr = 2'b00;
    s_state = '0;
    s_func = '0;
    s_d0 = '0;
    s_d1 = '0;
    repeat (2) begin
      pre();
      post();
    end
    s_rst = 1'b0;
    s_en = 1'b1;
    s_rr = 2'b11;
    pre();
    chk("reset_resp_valid", 64'(bus.resp_valid), 64'(2'b00));
    chk("reset_cfu_req_valid", 64'(cfu_req_valid), 64'(1'b0));
    post();

    s_valid = 2'b01;
    s_func[0] = 10'd0;
    s_d0[0] = 32'd3;
    s_d1[0] = 32'd4;
    pre();
    chk("mul_ready", 64'(bus.req_ready), 64'(2'b01));
    chk("mul_issue", 64'(cfu_req_valid), 64'(1'b1));
    post();
    s_valid = 2'b00;
    repeat (2) begin
      pre();
      chk("mul_wait", 64'(bus.resp_valid), 64'(2'b00));
      post();
    end
    pre();
    chk("mul_valid", 64'(bus.resp_valid), 64'(2'b01));
    chk("mul_data", 64'(bus.resp_data[0]), 64'd12);
    chk("mul_status", 64'(bus.resp_status[0]), 64'(CFU_OK));
    post();

    s_valid = 2'b10;
    s_func[1] = 10'd5;
    pre();
    chk("err_ready", 64'(bus.req_ready), 64'(2'b10));
    post();
    s_valid = 2'b00;
    repeat (2) begin
      pre();
      post();
    end
    pre();
    chk("err_valid", 64'(bus.resp_valid), 64'(2'b10));
    chk("err_status", 64'(bus.resp_status[1]), 64'(CFU_ERROR_FUNC));
    post();
    idle(2);

    s_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      pre();
      chk("alternate", 64'(bus.req_ready), k % 2 == 1 ? 64'(2'b10) : 64'(2'b01));
      post();
    end
    idle(5);

    s_rr = 2'b10;
    s_valid = 2'b11;
    for (int k = 0; k < 10; k++) begin
      rand_ops();
      pre();
      chk("bp_grant0", 64'(bus.req_ready[0]), 64'(k == 0 || k == 2));
      post();
    end
    s_rr = 2'b11;
    repeat (6) begin
      rand_ops();
      pre();
      post();
    end
    idle(6);

    s_valid = 2'b01;
    pre();
    post();
    s_valid = 2'b10;
    pre();
    post();
    s_en = 1'b0;
    s_valid = 2'b11;
    repeat (3) begin
      pre();
      chk("freeze_no_grant", 64'(bus.req_ready), 64'(2'b00));
      post();
    end
    s_en = 1'b1;
    s_valid = 2'b00;
    pre();
    chk("thaw_c0", 64'(bus.resp_valid), 64'(2'b00));
    post();
    pre();
    chk("thaw_c1", 64'(bus.resp_valid), 64'(2'b01));
    post();
    pre();
    chk("thaw_c2", 64'(bus.resp_valid), 64'(2'b10));
    post();
    idle(3);

    s_valid = 2'b10;
    pre();
    post();
    s_valid = 2'b01;
    pre();
    post();
    s_valid = 2'b00;
    s_rst = 1'b1;
    pre();
    post();
    s_rst = 1'b0;
    repeat (4) begin
      pre();
      chk("rst_flush", 64'(bus.resp_valid), 64'(2'b00));
      post();
    end
    s_valid = 2'b11;
    pre();
    chk("rst_ptr0", 64'(bus.req_ready), 64'(2'b01));
    post();
    idle(5);

    mode = 1;
    rr_fix = 2'b11;
    for (int c = 0; c < 1500; c++) begin
      if (c % 64 == 0) begin
        mode = $urandom_range(0, 2);
        rr_fix = 2'($urandom);
      end
      rand_ops();
      s_valid = 2'($urandom);
      s_rr = mode == 0 ? 2'($urandom) : mode == 1 ? 2'b11 : rr_fix;
      s_en = $urandom_range(0, 9) != 0;
      s_rst = $urandom_range(0, 255) == 0;
      pre();
      post();
    end
    s_rst = 1'b0;
    s_en = 1'b1;
    s_rr = 2'b11;
    idle(8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
